// File: rtl/flash_writer.sv
// flash_writer: word-program / block-erase initiator for a 16-bit Intel-command-set parallel NOR flash
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   req_i, op_i       start request (sampled in IDLE), 0 = word program, 1 = block erase
//   addr_i, data_i    23-bit word address and 16-bit program data, latched on accept
//   flash_*           registered flash bus: address, data out/oe, data in, ce_n, we_n, oe_n
//   pauseRequest_o    pipeline stall while an operation is in flight
//   done_o, error_o   one-cycle completion pulse and its failure flag
//   status_o          last sampled status register, held until overwritten by the next poll
module flash_writer #(
    parameter int          WE_CYCLES = 3,
    parameter int          RD_CYCLES = 2,
    parameter logic [31:0] TIMEOUT   = 32'd50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        op_i,
    input  logic [22:0] addr_i,
    input  logic [15:0] data_i,
    output logic [22:0] flash_addr_o,
    output logic [15:0] flash_data_o,
    output logic        flash_data_oe_o,
    input  logic [15:0] flash_data_i,
    output logic        flash_ce_n_o,
    output logic        flash_we_n_o,
    output logic        flash_oe_n_o,
    output logic        pauseRequest_o,
    output logic        done_o,
    output logic        error_o,
    output logic [7:0]  status_o
);
    typedef enum logic [2:0] {IDLE, W_SETUP, W_PULSE, W_HOLD, POLL_RD, POLL_GAP, DONE} state_t;
    localparam logic [3:0] WE_LAST = 4'(WE_CYCLES - 1);
    localparam logic [3:0] RD_LAST = 4'(RD_CYCLES - 1);
    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic [1:0]  step, step_nx;
    logic        op_q, op_nx, err, err_nx;
    logic [15:0] data_q, data_nx, cmd_nx;
    logic [31:0] polls;
    logic        sr_fail, poll_end, wr_nx;
    logic        unused_hi;
    assign unused_hi = ^flash_data_i[15:8];
    // A poll ends on SR7 or on the last allowed iteration; a missing SR7 counts as failure.
    assign sr_fail  = !status_o[7] || status_o[5] || status_o[4] || status_o[3] || status_o[1];
    assign poll_end = status_o[7] || polls == TIMEOUT - 32'd1;
    always_comb begin
        state_nx = state;
        step_nx  = step;
        err_nx   = err;
        op_nx    = op_q;
        data_nx  = data_q;
        case (state)
            IDLE: if (req_i) begin
                state_nx = W_SETUP;
                step_nx  = 2'd0;
                err_nx   = 1'b0;
                op_nx    = op_i;
                data_nx  = data_i;
            end
            W_SETUP: state_nx = W_PULSE;
            W_PULSE: state_nx = cnt == WE_LAST ? W_HOLD : W_PULSE;
            W_HOLD: begin
                state_nx = step == 2'd1 ? POLL_RD : step == 2'd3 ? DONE : W_SETUP;
                step_nx  = step[0] ? step : step + 2'd1;
            end
            POLL_RD: state_nx = cnt == RD_LAST ? POLL_GAP : POLL_RD;
            POLL_GAP: if (poll_end) begin
                state_nx = W_SETUP;
                err_nx   = sr_fail;
                step_nx  = sr_fail ? 2'd2 : 2'd3;
            end else begin
                state_nx = POLL_RD;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        cmd_nx = step_nx == 2'd0 ? (op_nx ? 16'h0020 : 16'h0040) :
                 step_nx == 2'd1 ? (op_nx ? 16'h00D0 : data_nx) :
                 step_nx == 2'd2 ? 16'h0050 : 16'h00FF;
        // The hold cycle before a poll releases the bus so data_oe and oe_n never meet back to back.
        wr_nx = state_nx == W_SETUP || state_nx == W_PULSE || (state_nx == W_HOLD && step_nx != 2'd1);
    end
    // Bus outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= 4'd0;
            step            <= 2'd0;
            err             <= 1'b0;
            op_q            <= 1'b0;
            data_q          <= 16'd0;
            polls           <= 32'd0;
            status_o        <= 8'd0;
            flash_addr_o    <= 23'd0;
            flash_data_o    <= 16'd0;
            flash_data_oe_o <= 1'b0;
            flash_ce_n_o    <= 1'b1;
            flash_we_n_o    <= 1'b1;
            flash_oe_n_o    <= 1'b1;
            pauseRequest_o  <= 1'b0;
            done_o          <= 1'b0;
            error_o         <= 1'b0;
        end else begin
            state           <= state_nx;
            cnt             <= (state_nx == state && state != IDLE) ? cnt + 4'd1 : 4'd0;
            step            <= step_nx;
            err             <= err_nx;
            op_q            <= op_nx;
            data_q          <= data_nx;
            polls           <= state == IDLE ? 32'd0 : state == POLL_GAP ? polls + 32'd1 : polls;
            if (state == POLL_RD && cnt == RD_LAST) status_o <= flash_data_i[7:0];
            if (state == IDLE && req_i) flash_addr_o <= addr_i;
            if (state_nx == W_SETUP) flash_data_o <= cmd_nx;
            flash_data_oe_o <= wr_nx;
            flash_ce_n_o    <= state_nx == IDLE || state_nx == DONE;
            flash_we_n_o    <= state_nx != W_PULSE;
            flash_oe_n_o    <= state_nx != POLL_RD;
            pauseRequest_o  <= state_nx != IDLE;
            done_o          <= state_nx == DONE;
            error_o         <= state_nx == DONE && err_nx;
        end
    end
endmodule

// File: tb/tb_flash_writer.sv
// tb_flash_writer: scoreboard bench for flash_writer with a status-register flash model
module tb_flash_writer;
    logic        clk = 1'b0, rst = 1'b1, req_i = 1'b0, op_i = 1'b0;
    logic [22:0] addr_i = '0;
    logic [15:0] data_i = '0;
    logic [22:0] flash_addr_o;
    logic [15:0] flash_data_o, flash_data_i;
    logic        flash_data_oe_o, flash_ce_n_o, flash_we_n_o, flash_oe_n_o;
    logic        pauseRequest_o, done_o, error_o;
    logic [7:0]  status_o;
    logic [7:0]  sr_first = 8'h00, sr_rest = 8'h00;
    int          rd_idx = 0;
    int          checks = 0, errors = 0;
    typedef struct {
        logic       err;
        logic [7:0] status;
        int         polls;
        int         lat;
    } done_t;
    logic [38:0] wr_q[$];
    done_t       dn_q[$];
    logic [38:0] wexp;
    done_t       dexp;
    logic        we_prev = 1'b1, oe_prev = 1'b1, doe_prev = 1'b0, pause_prev = 1'b0;
    int          we_lo = 0, polls = 0, t = 0;

    flash_writer #(.WE_CYCLES(3), .RD_CYCLES(2), .TIMEOUT(32'd4)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .op_i(op_i), .addr_i(addr_i), .data_i(data_i),
        .flash_addr_o(flash_addr_o), .flash_data_o(flash_data_o), .flash_data_oe_o(flash_data_oe_o),
        .flash_data_i(flash_data_i), .flash_ce_n_o(flash_ce_n_o), .flash_we_n_o(flash_we_n_o),
        .flash_oe_n_o(flash_oe_n_o), .pauseRequest_o(pauseRequest_o), .done_o(done_o),
        .error_o(error_o), .status_o(status_o)
    );

    always #5 clk = ~clk;

    // Flash model: the first read of an operation returns sr_first, later reads return sr_rest.
    assign flash_data_i = {8'h00, (rd_idx == 0) ? sr_first : sr_rest};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever a bus write completes or done_o pulses.
    always @(negedge clk) begin
        if (rst) begin
            we_prev = 1'b1; oe_prev = 1'b1; doe_prev = 1'b0; pause_prev = 1'b0;
            we_lo = 0; polls = 0; t = 0; rd_idx = 0;
        end else begin
            if ((flash_data_oe_o && !flash_oe_n_o) || (doe_prev && !flash_oe_n_o) || (!oe_prev && flash_data_oe_o)) begin
                errors++;
                $display("FAIL turnaround: data_oe=%b oe_n=%b prev_data_oe=%b prev_oe_n=%b",
                         flash_data_oe_o, flash_oe_n_o, doe_prev, oe_prev);
            end
            if (error_o && !done_o) begin
                errors++;
                $display("FAIL error_outside_done: error_o=1 done_o=0");
            end
            if (pauseRequest_o && !pause_prev) begin t = 0; polls = 0; end
            else t++;
            if (!pauseRequest_o) rd_idx = 0;
            else if (flash_oe_n_o && !oe_prev) rd_idx++;
            if (!flash_oe_n_o && oe_prev) polls++;
            if (!flash_we_n_o) we_lo++;
            if (flash_we_n_o && !we_prev) begin
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", flash_addr_o, flash_data_o);
                end else begin
                    wexp = wr_q.pop_front();
                    chk("write_addr", 32'(flash_addr_o), 32'(wexp[38:16]));
                    chk("write_data", 32'(flash_data_o), 32'(wexp[15:0]));
                    chk("we_low_cycles", we_lo, 3);
                    chk("write_ce_n", 32'(flash_ce_n_o), 0);
                end
                we_lo = 0;
            end
            if (done_o) begin
                if (dn_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: error_o %b status 0x%0h", error_o, status_o);
                end else begin
                    dexp = dn_q.pop_front();
                    chk("done_error", 32'(error_o), 32'(dexp.err));
                    chk("done_status", 32'(status_o), 32'(dexp.status));
                    chk("done_polls", polls, dexp.polls);
                    chk("done_latency", t, dexp.lat);
                    chk("done_ce_n", 32'(flash_ce_n_o), 1);
                end
            end
            we_prev = flash_we_n_o; oe_prev = flash_oe_n_o;
            doe_prev = flash_data_oe_o; pause_prev = pauseRequest_o;
        end
    end

    task automatic push_exp(input logic op, input logic [22:0] a, input logic [15:0] d, input logic fail,
                            input int np, input logic [7:0] st, input int lat);
        wr_q.push_back({a, op ? 16'h0020 : 16'h0040});
        wr_q.push_back({a, op ? 16'h00D0 : d});
        if (fail) wr_q.push_back({a, 16'h0050});
        wr_q.push_back({a, 16'h00FF});
        dn_q.push_back('{fail, st, np, lat});
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(done_o), 1);
    endtask

    task automatic issue(input logic op, input logic [22:0] a, input logic [15:0] d);
        @(negedge clk);
        op_i = op; addr_i = a; data_i = d; req_i = 1'b1;
        @(negedge clk);
        req_i = 1'b0; op_i = ~op; addr_i = '1; data_i = '1;
    endtask

    task automatic run_op(input logic op, input logic [22:0] a, input logic [15:0] d, input logic [7:0] s0,
                          input logic [7:0] s1, input logic fail, input int np, input logic [7:0] st, input int lat);
        push_exp(op, a, d, fail, np, st, lat);
        sr_first = s0; sr_rest = s1;
        issue(op, a, d);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        @(negedge clk); @(negedge clk);
        chk("rst_ce_n", 32'(flash_ce_n_o), 1);
        chk("rst_we_n", 32'(flash_we_n_o), 1);
        chk("rst_oe_n", 32'(flash_oe_n_o), 1);
        chk("rst_data_oe", 32'(flash_data_oe_o), 0);
        chk("rst_addr", 32'(flash_addr_o), 0);
        chk("rst_data", 32'(flash_data_o), 0);
        chk("rst_pause", 32'(pauseRequest_o), 0);
        chk("rst_done_err", 32'({done_o, error_o}), 0);
        chk("rst_status", 32'(status_o), 0);
        rst = 1'b0;
        run_op(1'b0, 23'h000123, 16'hBEEF, 8'h00, 8'h80, 1'b0, 2, 8'h80, 21);
        run_op(1'b1, 23'h010000, 16'h0000, 8'h80, 8'h80, 1'b0, 1, 8'h80, 18);
        run_op(1'b1, 23'h020000, 16'h0000, 8'hA0, 8'hA0, 1'b1, 1, 8'hA0, 23);
        run_op(1'b0, 23'h000456, 16'h1111, 8'h00, 8'h00, 1'b1, 4, 8'h00, 32);
        // Reset in the middle of the first write pulse.
        sr_first = 8'h00; sr_rest = 8'h80;
        issue(1'b0, 23'h000321, 16'hCAFE);
        n = 0;
        while (flash_we_n_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reached_w_pulse", 32'(flash_we_n_o), 0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_we_n", 32'(flash_we_n_o), 1);
        chk("async_rst_ce_n", 32'(flash_ce_n_o), 1);
        chk("async_rst_data_oe", 32'(flash_data_oe_o), 0);
        chk("async_rst_pause", 32'(pauseRequest_o), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        run_op(1'b0, 23'h000777, 16'h5A5A, 8'h00, 8'h80, 1'b0, 2, 8'h80, 21);
        // req_i held high: one operation, then exactly one more accepted in the IDLE cycle.
        sr_first = 8'h80; sr_rest = 8'h80;
        push_exp(1'b0, 23'h00ABCD, 16'h1234, 1'b0, 1, 8'h80, 18);
        push_exp(1'b0, 23'h00ABCD, 16'h1234, 1'b0, 1, 8'h80, 18);
        @(negedge clk);
        op_i = 1'b0; addr_i = 23'h00ABCD; data_i = 16'h1234; req_i = 1'b1;
        @(negedge clk);
        wait_done();
        @(negedge clk);
        chk("idle_after_done", 32'(pauseRequest_o), 0);
        @(negedge clk);
        chk("second_accept", 32'(pauseRequest_o), 1);
        req_i = 1'b0;
        wait_done();
        repeat (10) @(negedge clk);
        chk("no_third_op", 32'(pauseRequest_o), 0);
        chk("writes_drained", wr_q.size(), 0);
        chk("dones_drained", dn_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
